// File: rtl/simon_button_input_if.sv
// Player-button bundle between the board buttons/Simon core and the button front end.
// The slave modport is the front end; the master modport is whatever drives it.
interface simon_button_input_if;
    logic [3:0] buttons;
    logic       simonTurn;
    logic       gameOver;
    logic [1:0] playerNum;
    logic       playerPressed;
    logic       multiPress;
    logic       stuck;

    modport master (
        output buttons, simonTurn, gameOver,
        input  playerNum, playerPressed, multiPress, stuck
    );

    modport slave (
        input  buttons, simonTurn, gameOver,
        output playerNum, playerPressed, multiPress, stuck
    );
endinterface

// File: rtl/simon_button_input.sv
// Simon player-button front end: synchronise, debounce per button, then accept exactly
// one clean press at a time, rejecting chords, held-over input and stuck buttons.
module simon_button_input #(
    parameter int DEBOUNCE_TICKS = 3,
    parameter int MAX_HOLD_TICKS = 120
) (
    input  logic                  clk,
    input  logic                  reset,
    simon_button_input_if.slave   bif
);
    localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
    localparam int HW = $clog2(MAX_HOLD_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_TICKS - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD_TICKS - 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD_TICKS);

    typedef enum logic [1:0] {IDLE, PRESS, WAIT_REL, STUCK} state_t;

    logic [3:0] sync1_q;
    logic [3:0] bsync_q;
    logic [3:0] db;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= '0;
            bsync_q <= '0;
        end else begin
            sync1_q <= bif.buttons;
            bsync_q <= sync1_q;
        end
    end

    // Each bit debounces independently: the level flips only after a full run of mismatches.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_db
            logic          db_q;
            logic [CW-1:0] cnt_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    db_q  <= 1'b0;
                    cnt_q <= '0;
                end else if (bsync_q[gi] == db_q) begin
                    cnt_q <= '0;
                end else if (cnt_q == CNT_LAST) begin
                    db_q  <= ~db_q;
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end

            assign db[gi] = db_q;
        end
    endgenerate

    state_t        state_q, state_d;
    logic [1:0]    num_q, num_d;
    logic          pressed_q, pressed_d;
    logic          multi_q, multi_d;
    logic          stuck_q, stuck_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          lock_q;
    logic          lock;
    logic [1:0]    db_idx;

    assign lock = bif.simonTurn | bif.gameOver;

    always_comb begin
        db_idx = '0;
        for (int i = 0; i < 4; i++) begin
            if (db[i]) db_idx = 2'(i);
        end
    end

    always_comb begin
        state_d   = state_q;
        num_d     = num_q;
        pressed_d = 1'b0;
        multi_d   = 1'b0;
        stuck_d   = 1'b0;
        hold_d    = hold_q;
        case (state_q)
            IDLE: begin
                if (!lock) begin
                    // A button still down as the lock falls was pressed during Simon's turn.
                    if (lock_q && db != 4'b0) begin
                        state_d = WAIT_REL;
                    end else if ($onehot(db)) begin
                        state_d   = PRESS;
                        num_d     = db_idx;
                        pressed_d = 1'b1;
                        hold_d    = '0;
                    end else if (db != 4'b0) begin
                        state_d = WAIT_REL;
                        multi_d = 1'b1;
                    end
                end
            end
            PRESS: begin
                pressed_d = 1'b1;
                hold_d    = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
                if (lock) begin
                    state_d   = WAIT_REL;
                    pressed_d = 1'b0;
                end else if (!db[num_q]) begin
                    state_d   = (db == 4'b0) ? IDLE : WAIT_REL;
                    pressed_d = 1'b0;
                end else if (hold_q == HOLD_LAST) begin
                    state_d   = STUCK;
                    pressed_d = 1'b0;
                    stuck_d   = 1'b1;
                end
            end
            WAIT_REL: begin
                if (db == 4'b0) state_d = IDLE;
            end
            STUCK: begin
                stuck_d = 1'b1;
                if (db == 4'b0) begin
                    state_d = IDLE;
                    stuck_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            num_q     <= '0;
            pressed_q <= 1'b0;
            multi_q   <= 1'b0;
            stuck_q   <= 1'b0;
            hold_q    <= '0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            num_q     <= num_d;
            pressed_q <= pressed_d;
            multi_q   <= multi_d;
            stuck_q   <= stuck_d;
            hold_q    <= hold_d;
            lock_q    <= lock;
        end
    end

    assign bif.playerNum     = num_q;
    assign bif.playerPressed = pressed_q;
    assign bif.multiPress    = multi_q;
    assign bif.stuck         = stuck_q;
endmodule

// File: tb/tb_simon_button_input.sv
// Scoreboard bench for simon_button_input: each stimulus step queues the outputs it
// should produce at a given edge; a negedge monitor pops and compares them.
module tb_simon_button_input;
    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   tests_run = 0;
    int   tests_failed = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    simon_button_input_if bif();

    simon_button_input #(
        .DEBOUNCE_TICKS(3),
        .MAX_HOLD_TICKS(120)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bif   (bif.slave)
    );

    // Expected outputs packed as {playerNum[1:0], playerPressed, multiPress, stuck}.
    typedef struct {
        int         at;
        string      tag;
        logic [4:0] val;
    } exp_t;

    exp_t sb[$];
    exp_t cur_e;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        if (obs !== expv) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end else begin
            $display("[TB] ok   %s: %0h (cycle %0d)", tag, obs, cyc);
        end
    endtask

    task automatic expect_out(input int at, input string tag, input logic [1:0] num,
                              input logic pp, input logic mp, input logic st);
        exp_t e;
        e.at  = at;
        e.tag = tag;
        e.val = {num, pp, mp, st};
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].at <= cyc) begin
            cur_e = sb.pop_front();
            check(cur_e.tag,
                  {27'd0, bif.playerNum, bif.playerPressed, bif.multiPress, bif.stuck},
                  {27'd0, cur_e.val});
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        reset         = 1'b1;
        bif.buttons   = 4'b0000;
        bif.simonTurn = 1'b0;
        bif.gameOver  = 1'b0;
        tick(3);
        c = cyc;
        expect_out(c, "reset", 2'd0, 0, 0, 0);
        reset = 1'b0;
        tick(5);

        // Single press: 6-cycle latency on press and on release.
        c = cyc;
        bif.buttons = 4'b0100;
        expect_out(c + 5, "t1_lat5", 2'd0, 0, 0, 0);
        expect_out(c + 6, "t1_press", 2'd2, 1, 0, 0);
        tick(10);
        c = cyc;
        bif.buttons = 4'b0000;
        expect_out(c + 5, "t1_hold", 2'd2, 1, 0, 0);
        expect_out(c + 6, "t1_rel", 2'd2, 0, 0, 0);
        tick(10);

        // 2-cycle glitch is filtered; a 3-cycle pulse just passes.
        c = cyc;
        bif.buttons = 4'b0010;
        tick(2);
        bif.buttons = 4'b0000;
        expect_out(c + 6, "t2_glitch", 2'd2, 0, 0, 0);
        expect_out(c + 9, "t2_glitch_late", 2'd2, 0, 0, 0);
        tick(10);
        c = cyc;
        bif.buttons = 4'b0010;
        tick(3);
        bif.buttons = 4'b0000;
        expect_out(c + 5, "t2_pulse_pre", 2'd2, 0, 0, 0);
        expect_out(c + 6, "t2_pulse_acc", 2'd1, 1, 0, 0);
        expect_out(c + 8, "t2_pulse_hold", 2'd1, 1, 0, 0);
        expect_out(c + 9, "t2_pulse_rel", 2'd1, 0, 0, 0);
        tick(10);

        // Chord rejected with a single-cycle multiPress, then a clean press accepted.
        c = cyc;
        bif.buttons = 4'b0011;
        expect_out(c + 6, "t3_multi", 2'd1, 0, 1, 0);
        expect_out(c + 7, "t3_multi_end", 2'd1, 0, 0, 0);
        tick(10);
        bif.buttons = 4'b0000;
        tick(10);
        c = cyc;
        bif.buttons = 4'b1000;
        expect_out(c + 6, "t3_accept", 2'd3, 1, 0, 0);
        tick(10);
        bif.buttons = 4'b0000;
        tick(10);

        // First press wins; releasing it with another held waits for full release.
        c = cyc;
        bif.buttons = 4'b0001;
        expect_out(c + 6, "t4_press", 2'd0, 1, 0, 0);
        tick(8);
        bif.buttons = 4'b1001;
        tick(4);
        bif.buttons = 4'b1000;
        expect_out(c + 17, "t4_hold", 2'd0, 1, 0, 0);
        expect_out(c + 18, "t4_rel0", 2'd0, 0, 0, 0);
        expect_out(c + 25, "t4_wait", 2'd0, 0, 0, 0);
        tick(14);
        bif.buttons = 4'b0000;
        tick(10);
        bif.buttons = 4'b0100;
        expect_out(c + 42, "t4_repress", 2'd2, 1, 0, 0);
        tick(10);
        bif.buttons = 4'b0000;
        tick(10);

        // Held-over input across simonTurn, then lock rising during PRESS.
        c = cyc;
        bif.simonTurn = 1'b1;
        bif.buttons   = 4'b0001;
        expect_out(c + 8, "t5_locked", 2'd2, 0, 0, 0);
        tick(10);
        bif.simonTurn = 1'b0;
        expect_out(c + 16, "t5_held_over", 2'd2, 0, 0, 0);
        tick(8);
        bif.buttons = 4'b0000;
        tick(10);
        bif.buttons = 4'b0001;
        expect_out(c + 34, "t5_repress", 2'd0, 1, 0, 0);
        tick(8);
        bif.simonTurn = 1'b1;
        expect_out(c + 37, "t5_lock_in_press", 2'd0, 0, 0, 0);
        tick(2);
        bif.simonTurn = 1'b0;
        bif.buttons   = 4'b0000;
        tick(10);

        // gameOver locks input as well.
        c = cyc;
        bif.gameOver = 1'b1;
        bif.buttons  = 4'b0100;
        expect_out(c + 8, "t5_gameover", 2'd0, 0, 0, 0);
        tick(10);
        bif.buttons = 4'b0000;
        tick(8);
        bif.gameOver = 1'b0;
        tick(10);

        // Hold timeout to STUCK and back.
        c = cyc;
        bif.buttons = 4'b0100;
        expect_out(c + 6, "t6_press", 2'd2, 1, 0, 0);
        expect_out(c + 125, "t6_last_active", 2'd2, 1, 0, 0);
        expect_out(c + 126, "t6_stuck", 2'd2, 0, 0, 1);
        tick(130);
        bif.buttons = 4'b0000;
        expect_out(c + 135, "t6_stuck_hold", 2'd2, 0, 0, 1);
        expect_out(c + 136, "t6_unstuck", 2'd2, 0, 0, 0);
        tick(10);

        // Reset mid-PRESS clears outputs; the still-held button re-debounces as a new press.
        c = cyc;
        bif.buttons = 4'b0010;
        expect_out(c + 8, "t6_pre_rst", 2'd1, 1, 0, 0);
        tick(8);
        reset = 1'b1;
        expect_out(c + 9, "t6_rst", 2'd0, 0, 0, 0);
        tick(1);
        reset = 1'b0;
        expect_out(c + 14, "t6_rst_lat", 2'd0, 0, 0, 0);
        expect_out(c + 15, "t6_after_rst", 2'd1, 1, 0, 0);
        tick(10);
        bif.buttons = 4'b0000;
        tick(15);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
